// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave timer controller.
// Contents: FSM state enum, 7-segment patterns (active-low {g,f,e,d,c,b,a}),
// datapath widths, default clock rate, keypad priority encoder.
package microwave_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 100;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned SEG_W          = 7;
    localparam int unsigned KEY_W          = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

    // Highest set key wins when several keys are pressed together.
    function automatic logic [DIGIT_W-1:0] key_to_digit(input logic [KEY_W-1:0] keys);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int i = 0; i < int'(KEY_W); i++) begin
            if (keys[i]) d = DIGIT_W'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/microwave_seg7_digit.sv
// BCD to 7-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Ports: bcd (4-bit digit in), segs_c (7-bit segments, combinational).
// Codes 10..15 decode to blank.
module seg7_digit
    import microwave_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   segs_c
);

    always_comb begin
        segs_c = SEG_BLANK;
        case (bcd)
            4'd0:    segs_c = SEG_0;
            4'd1:    segs_c = SEG_1;
            4'd2:    segs_c = SEG_2;
            4'd3:    segs_c = SEG_3;
            4'd4:    segs_c = SEG_4;
            4'd5:    segs_c = SEG_5;
            4'd6:    segs_c = SEG_6;
            4'd7:    segs_c = SEG_7;
            4'd8:    segs_c = SEG_8;
            4'd9:    segs_c = SEG_9;
            default: segs_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/microwave.sv
// Microwave-oven timer controller: keypad M:SS entry, start/stop/door control,
// 1 Hz countdown and magnetron enable.
// Ports:
//   clk, clearn (async active-low reset)
//   startn, stopn (active-low buttons), door_closed (1 = closed)
//   keypad[9:0] one-hot digit keys
//   secs_ones_segs, secs_tens_segs, min_segs: registered active-low 7-seg
//   mag_on: magnetron enable, decoded from the state register
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module microwave
    import microwave_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEFAULT_CLK_HZ,
    parameter int unsigned SYNC_FF = 2
) (
    input  logic               clk,
    input  logic               clearn,
    input  logic               startn,
    input  logic               stopn,
    input  logic               door_closed,
    input  logic [KEY_W-1:0]   keypad,
    output logic [SEG_W-1:0]   secs_ones_segs,
    output logic [SEG_W-1:0]   secs_tens_segs,
    output logic [SEG_W-1:0]   min_segs,
    output logic               mag_on
);

    localparam int unsigned IN_W  = KEY_W + 3;
    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [IN_W-1:0] IN_RST = {1'b1, 1'b1, 1'b0, {KEY_W{1'b0}}};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [SEG_W-1:0] TENS_RST = SEG_BLANK;
    localparam logic [SEG_W-1:0] MIN_RST  = SEG_BLANK;
`else
    localparam logic [SEG_W-1:0] TENS_RST = SEG_0;
    localparam logic [SEG_W-1:0] MIN_RST  = SEG_0;
`endif

    // Input synchronizer chain for all board inputs, bundled into one vector.
    logic [IN_W-1:0] sync_q [SYNC_FF];

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            for (int i = 0; i < int'(SYNC_FF); i++) sync_q[i] <= IN_RST;
        end else begin
            sync_q[0] <= {startn, stopn, door_closed, keypad};
            for (int i = 1; i < int'(SYNC_FF); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic             start_s;
    logic             stop_s;
    logic             door_s;
    logic [KEY_W-1:0] key_s;

    assign start_s = sync_q[SYNC_FF-1][IN_W-1];
    assign stop_s  = sync_q[SYNC_FF-1][IN_W-2];
    assign door_s  = sync_q[SYNC_FF-1][IN_W-3];
    assign key_s   = sync_q[SYNC_FF-1][KEY_W-1:0];

    // Edge detectors: one action per button press / key press.
    logic start_q;
    logic stop_q;
    logic key_any_q;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            start_q   <= 1'b1;
            stop_q    <= 1'b1;
            key_any_q <= 1'b0;
        end else begin
            start_q   <= start_s;
            stop_q    <= stop_s;
            key_any_q <= |key_s;
        end
    end

    logic start_fall_c;
    logic stop_fall_c;
    logic key_press_c;

    assign start_fall_c = start_q & ~start_s;
    assign stop_fall_c  = stop_q & ~stop_s;
    assign key_press_c  = (|key_s) & ~key_any_q;

    // State and time registers.
    state_t             state_q, state_d;
    logic [DIGIT_W-1:0] min_q, min_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;

    // Prescaler: held at zero outside COOK, so every COOK entry starts a full second.
    logic [PRE_W-1:0] pre_cnt_q;
    logic             tick_c;

    assign tick_c = (state_q == COOK) && (pre_cnt_q == PRE_W'(CLK_HZ - 1));

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            pre_cnt_q <= '0;
        end else if ((state_q != COOK) || tick_c) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
        end
    end

    logic time_nz_c;
    logic time_one_c;

    assign time_nz_c  = |{min_q, tens_q, ones_q};
    assign time_one_c = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q <= IDLE;
            min_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    // Next-state and time-update logic; stop always has priority over start.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (stop_fall_c) begin
                    min_d  = '0;
                    tens_d = '0;
                    ones_d = '0;
                end else if (start_fall_c) begin
                    if (door_s && time_nz_c) state_d = COOK;
                end else if (key_press_c) begin
                    min_d  = tens_q;
                    tens_d = (ones_q > 4'd5) ? 4'd5 : ones_q;
                    ones_d = key_to_digit(key_s);
                end
            end
            COOK: begin
                if (stop_fall_c || !door_s) begin
                    state_d = PAUSE;
                end else if (tick_c) begin
                    if (time_one_c) begin
                        state_d = IDLE;
                        ones_d  = '0;
                    end else if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        if (tens_q != 4'd0) begin
                            tens_d = tens_q - 4'd1;
                        end else begin
                            tens_d = 4'd5;
                            min_d  = min_q - 4'd1;
                        end
                    end
                end
            end
            PAUSE: begin
                if (stop_fall_c) begin
                    state_d = IDLE;
                    min_d   = '0;
                    tens_d  = '0;
                    ones_d  = '0;
                end else if (start_fall_c && door_s) begin
                    state_d = COOK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mag_on = (state_q == COOK);

    // Segment decode and display registers.
    logic [SEG_W-1:0] ones_seg_c;
    logic [SEG_W-1:0] tens_seg_c;
    logic [SEG_W-1:0] min_seg_c;
    logic [SEG_W-1:0] tens_disp_c;
    logic [SEG_W-1:0] min_disp_c;

    seg7_digit u_ones (.bcd(ones_q), .segs_c(ones_seg_c));
    seg7_digit u_tens (.bcd(tens_q), .segs_c(tens_seg_c));
    seg7_digit u_min  (.bcd(min_q),  .segs_c(min_seg_c));

    always_comb begin
        tens_disp_c = tens_seg_c;
        min_disp_c  = min_seg_c;
`ifdef LEADING_ZERO_BLANK_EN
        if (min_q == 4'd0) begin
            min_disp_c = SEG_BLANK;
            if (tens_q == 4'd0) tens_disp_c = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            secs_ones_segs <= SEG_0;
            secs_tens_segs <= TENS_RST;
            min_segs       <= MIN_RST;
        end else begin
            secs_ones_segs <= ones_seg_c;
            secs_tens_segs <= tens_disp_c;
            min_segs       <= min_disp_c;
        end
    end

endmodule

// File: tb/tb_microwave.sv
// Directed self-checking bench for the microwave timer controller.
// One time unit = 1 ms; 10 ms clock, CLK_HZ = 100.
module tb_microwave;

    logic       clk;
    logic       clearn;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic [9:0] keypad;
    logic [6:0] secs_ones_segs;
    logic [6:0] secs_tens_segs;
    logic [6:0] min_segs;
    logic       mag_on;

    int n_cmp;
    int n_err;

    microwave #(.CLK_HZ(100), .SYNC_FF(2)) dut (
        .clk            (clk),
        .clearn         (clearn),
        .startn         (startn),
        .stopn          (stopn),
        .door_closed    (door_closed),
        .keypad         (keypad),
        .secs_ones_segs (secs_ones_segs),
        .secs_tens_segs (secs_tens_segs),
        .min_segs       (min_segs),
        .mag_on         (mag_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {min, tens, ones} segment word for a displayed time M:TO.
    function automatic logic [31:0] disp(input int m, input int t, input int o);
        logic [6:0] sm, st;
        sm = seg(m);
        st = seg(t);
`ifdef LEADING_ZERO_BLANK_EN
        if (m == 0) begin
            sm = 7'h7F;
            if (t == 0) st = 7'h7F;
        end
`endif
        return {11'd0, sm, st, seg(o)};
    endfunction

    function automatic logic [31:0] shown();
        return {11'd0, min_segs, secs_tens_segs, secs_ones_segs};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int d);
        keypad = 10'b1 << d;
        cyc(4);
        keypad = '0;
        cyc(4);
    endtask

    task automatic press_start();
        startn = 1'b0;
        cyc(4);
        startn = 1'b1;
        cyc(4);
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        cyc(4);
        stopn = 1'b1;
        cyc(4);
    endtask

    task automatic press_both();
        startn = 1'b0;
        stopn  = 1'b0;
        cyc(4);
        startn = 1'b1;
        stopn  = 1'b1;
        cyc(4);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        clearn      = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        door_closed = 1'b0;
        keypad      = '0;

        cyc(3);
        check("rst_disp", shown(), disp(0, 0, 0));
        check("rst_mag", 32'(mag_on), 32'd0);
        clearn = 1'b1;
        cyc(2);
        check("post_rst_disp", shown(), disp(0, 0, 0));

        // Entry shifting and tens clamp.
        press_key(2);
        check("key_2", shown(), disp(0, 0, 2));
        press_key(5);
        press_key(9);
        check("key_259", shown(), disp(2, 5, 9));
        check("key_mag", 32'(mag_on), 32'd0);
        press_key(9);
        check("clamp_1", shown(), disp(5, 5, 9));
        press_key(9);
        check("clamp_2", shown(), disp(5, 5, 9));

        // Start with the door open is ignored.
        press_start();
        check("door_open_mag", 32'(mag_on), 32'd0);
        check("door_open_disp", shown(), disp(5, 5, 9));

        // Cook, two ticks.
        door_closed = 1'b1;
        cyc(4);
        press_start();
        check("cook_mag", 32'(mag_on), 32'd1);
        cyc(200);
        check("cook_2s", shown(), disp(5, 5, 7));

        // Stop freezes the count.
        press_stop();
        check("stop_mag", 32'(mag_on), 32'd0);
        cyc(150);
        check("stop_frozen", shown(), disp(5, 5, 7));

        // Resume.
        press_start();
        check("resume_mag", 32'(mag_on), 32'd1);
        cyc(100);
        check("resume_1s", shown(), disp(5, 5, 6));

        // Door open during cook.
        door_closed = 1'b0;
        cyc(1);
        check("door_lat_1", 32'(mag_on), 32'd1);
        cyc(2);
        check("door_lat_3", 32'(mag_on), 32'd0);
        door_closed = 1'b1;
        cyc(150);
        check("door_close_mag", 32'(mag_on), 32'd0);
        check("door_close_disp", shown(), disp(5, 5, 6));

        // Stop in PAUSE clears.
        press_stop();
        check("pause_stop", shown(), disp(0, 0, 0));
        check("pause_stop_mag", 32'(mag_on), 32'd0);

        // Held key gives one entry; multi-hot takes highest key; IDLE stop clears.
        keypad = 10'b1 << 1;
        cyc(20);
        keypad = '0;
        cyc(4);
        check("key_hold", shown(), disp(0, 0, 1));
        keypad = 10'b0010001000;
        cyc(4);
        keypad = '0;
        cyc(4);
        check("key_multi", shown(), disp(0, 1, 7));
        press_stop();
        check("idle_stop", shown(), disp(0, 0, 0));

        // Double borrow 1:00 -> 0:59, keys ignored while cooking.
        press_key(1);
        press_key(0);
        press_key(0);
        check("load_100", shown(), disp(1, 0, 0));
        press_start();
        press_key(4);
        cyc(92);
        check("borrow", shown(), disp(0, 5, 9));

        // Simultaneous start and stop: stop wins.
        press_both();
        check("both_mag", 32'(mag_on), 32'd0);
        cyc(150);
        check("both_frozen", shown(), disp(0, 5, 9));
        press_stop();
        check("both_clear", shown(), disp(0, 0, 0));

        // Run to zero.
        press_key(2);
        press_start();
        check("run0_mag_on", 32'(mag_on), 32'd1);
        cyc(200);
        check("run0_disp", shown(), disp(0, 0, 0));
        check("run0_mag_off", 32'(mag_on), 32'd0);
        press_start();
        check("zero_start", 32'(mag_on), 32'd0);

        // Async clear mid-cook.
        press_key(3);
        press_start();
        cyc(20);
        check("clr_pre_mag", 32'(mag_on), 32'd1);
        clearn = 1'b0;
        #1;
        check("clr_mag", 32'(mag_on), 32'd0);
        check("clr_disp", shown(), disp(0, 0, 0));
        cyc(2);
        clearn = 1'b1;
        cyc(4);
        check("clr_after", shown(), disp(0, 0, 0));
        check("clr_after_mag", 32'(mag_on), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
